// File: rtl/stft_framer.sv
// Overlapping-frame builder: circular sample buffer, frame trigger logic, and one pending-frame slot.
// Optional FRAMER_PREEMPH_EN applies 31/32 pre-emphasis to samples as they are written.
//   state  | meaning
//   S_IDLE | no frame being read
//   S_BUSY | reading FRAME_LEN consecutive buffer words
module stft_framer #(
   parameter int DW        = 14,
   parameter int FRAME_LEN = 256,
   parameter int HOP       = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          di_en,
   input  logic [DW-1:0] data_i,
   output logic          do_en,
   output logic [DW-1:0] data_o,
   output logic          do_first,
   output logic          do_last,
   output logic          ovf
);
   localparam int DEPTH = 2 * FRAME_LEN;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(FRAME_LEN + 1);
   localparam int HW    = (HOP > 1) ? $clog2(HOP) : 1;

   localparam logic [CW-1:0] FILL_MAX  = CW'(FRAME_LEN);
   localparam logic [CW-1:0] FILL_M1   = CW'(FRAME_LEN - 1);
   localparam logic [HW-1:0] HOP_M1    = HW'(HOP - 1);
   localparam logic [AW-1:0] CNT_MAX   = AW'(FRAME_LEN - 1);
   localparam logic [AW-1:0] FRAME_OFS = AW'(FRAME_LEN);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t        r_state, w_state_nxt;
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [CW-1:0] r_fill;
   logic [HW-1:0] r_hc;
   logic [AW-1:0] r_rd_addr, w_rd_addr_nxt;
   logic [AW-1:0] r_rd_cnt, w_rd_cnt_nxt;
   logic          r_pend, w_pend_nxt;
   logic [AW-1:0] r_pend_addr, w_pend_addr_nxt;
   logic          w_ovf_set, w_rd_en;
   logic [DW-1:0] r_rd_data;
   logic          r_rd_vld, r_rd_first, r_rd_last;
   logic          r_do_en, r_do_first, r_do_last, r_ovf;
   logic [DW-1:0] r_data_o;
   logic [DW-1:0] w_wdata;
   logic [AW-1:0] w_wp_next, w_start;
   logic          w_fill_full, w_trig;

`ifdef FRAMER_PREEMPH_EN
   logic [DW-1:0]        r_prev;
   logic signed [DW+1:0] w_x_ext, w_p_ext, w_pe;
   logic                 w_in_range;

   assign w_x_ext    = $signed({{2{data_i[DW-1]}}, data_i});
   assign w_p_ext    = $signed({{2{r_prev[DW-1]}}, r_prev});
   assign w_pe       = w_x_ext - w_p_ext + (w_p_ext >>> 5);
   assign w_in_range = (w_pe[DW+1:DW-1] == 3'b000) || (w_pe[DW+1:DW-1] == 3'b111);
   assign w_wdata    = w_in_range ? w_pe[DW-1:0]
                     : (w_pe[DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});

   always_ff @(posedge clk) begin
      if (rst)        r_prev <= '0;
      else if (di_en) r_prev <= data_i;
   end
`else
   assign w_wdata = data_i;
`endif

   assign w_wp_next   = r_wp + AW'(1);
   assign w_start     = w_wp_next - FRAME_OFS;
   assign w_fill_full = (r_fill == FILL_MAX);
   assign w_trig      = di_en && ((r_fill == FILL_M1) || (w_fill_full && (r_hc == HOP_M1)));

   always_comb begin
      w_state_nxt     = r_state;
      w_rd_addr_nxt   = r_rd_addr;
      w_rd_cnt_nxt    = r_rd_cnt;
      w_pend_nxt      = r_pend;
      w_pend_addr_nxt = r_pend_addr;
      w_ovf_set       = 1'b0;
      w_rd_en         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_trig) begin
               w_state_nxt   = S_BUSY;
               w_rd_addr_nxt = w_start;
               w_rd_cnt_nxt  = CNT_MAX;
            end
         end
         S_BUSY: begin
            w_rd_en       = 1'b1;
            w_rd_addr_nxt = r_rd_addr + AW'(1);
            w_rd_cnt_nxt  = r_rd_cnt - AW'(1);
            if (w_trig && r_pend) w_ovf_set = 1'b1;
            if (r_rd_cnt == '0) begin
               // Last read: chain straight into the next frame so do_en stays gapless.
               if (r_pend) begin
                  w_rd_addr_nxt = r_pend_addr;
                  w_rd_cnt_nxt  = CNT_MAX;
                  w_pend_nxt    = 1'b0;
               end else if (w_trig) begin
                  w_rd_addr_nxt = w_start;
                  w_rd_cnt_nxt  = CNT_MAX;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else if (w_trig && !r_pend) begin
               w_pend_nxt      = 1'b1;
               w_pend_addr_nxt = w_start;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (di_en) r_mem[r_wp] <= w_wdata;
      if (w_rd_en) r_rd_data <= r_mem[r_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_wp        <= '0;
         r_fill      <= '0;
         r_hc        <= '0;
         r_rd_addr   <= '0;
         r_rd_cnt    <= '0;
         r_pend      <= 1'b0;
         r_pend_addr <= '0;
         r_rd_vld    <= 1'b0;
         r_rd_first  <= 1'b0;
         r_rd_last   <= 1'b0;
         r_do_en     <= 1'b0;
         r_do_first  <= 1'b0;
         r_do_last   <= 1'b0;
         r_data_o    <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rd_addr   <= w_rd_addr_nxt;
         r_rd_cnt    <= w_rd_cnt_nxt;
         r_pend      <= w_pend_nxt;
         r_pend_addr <= w_pend_addr_nxt;
         r_ovf       <= r_ovf | w_ovf_set;
         if (di_en) begin
            r_wp <= w_wp_next;
            if (!w_fill_full)  r_fill <= r_fill + CW'(1);
            else               r_hc   <= (r_hc == HOP_M1) ? '0 : r_hc + HW'(1);
         end
         r_rd_vld   <= w_rd_en;
         r_rd_first <= w_rd_en && (r_rd_cnt == CNT_MAX);
         r_rd_last  <= w_rd_en && (r_rd_cnt == '0);
         r_do_en    <= r_rd_vld;
         r_do_first <= r_rd_vld && r_rd_first;
         r_do_last  <= r_rd_vld && r_rd_last;
         if (r_rd_vld) r_data_o <= r_rd_data;
      end
   end

   assign do_en    = r_do_en;
   assign data_o   = r_data_o;
   assign do_first = r_do_first;
   assign do_last  = r_do_last;
   assign ovf      = r_ovf;
endmodule

// File: tb/tb_stft_framer.sv
// Randomised and directed bench for stft_framer against a frame-scheduling reference model.
module tb_stft_framer;
   localparam int DW   = 14;
   localparam int FL   = 8;
   localparam int HOP  = 4;
   localparam int NMAX = 256;

   logic          clk = 1'b0;
   logic          rst, di_en;
   logic [DW-1:0] data_i;
   logic          do_en, do_first, do_last, ovf;
   logic [DW-1:0] data_o;

   int checks = 0;
   int errors = 0;

   logic          st_rst [NMAX];
   logic          st_en  [NMAX];
   logic [DW-1:0] st_d   [NMAX];
   logic          ob_en [NMAX], ob_first [NMAX], ob_last [NMAX], ob_ovf [NMAX];
   logic [DW-1:0] ob_d  [NMAX];
   logic          ex_en [NMAX], ex_first [NMAX], ex_last [NMAX], ex_ovf [NMAX];
   logic          ex_drop [NMAX], ex_rsted [NMAX];
   logic [DW-1:0] ex_d  [NMAX];

   always #5 clk = ~clk;

   stft_framer #(.DW(DW), .FRAME_LEN(FL), .HOP(HOP)) dut (
      .clk(clk), .rst(rst), .di_en(di_en), .data_i(data_i),
      .do_en(do_en), .data_o(data_o), .do_first(do_first), .do_last(do_last), .ovf(ovf)
   );

   function automatic void clear_stim();
      for (int i = 0; i < NMAX; i++) begin
         st_rst[i] = 1'b0;
         st_en[i]  = 1'b0;
         st_d[i]   = '0;
      end
      st_rst[0] = 1'b1;
   endfunction

   // Reference: each trigger yields the last FL stored samples; scheduling follows the
   // one-pending-slot rule expressed on output-start times.
   task automatic build_expected(input int n);
      logic [DW-1:0] hist[$];
      logic [DW-1:0] v, prev;
      int nw, last_s, s, t, y, p;
      logic ov;
      for (int k = 0; k <= n; k++) begin
         ex_en[k] = 0; ex_first[k] = 0; ex_last[k] = 0; ex_drop[k] = 0; ex_rsted[k] = 0; ex_d[k] = '0;
      end
      nw = 0; last_s = -1000; p = 0;
      for (int c = 0; c < n; c++) begin
         if (st_rst[c]) begin
            for (int k = c + 1; k <= n; k++) begin
               ex_en[k] = 0; ex_first[k] = 0; ex_last[k] = 0;
            end
            ex_rsted[c+1] = 1'b1;
            nw = 0; hist.delete(); last_s = -1000; p = 0;
         end else if (st_en[c]) begin
`ifdef FRAMER_PREEMPH_EN
            y = int'($signed(st_d[c])) - p + (p >>> 5);
            if (y > 8191) y = 8191;
            if (y < -8192) y = -8192;
            p = int'($signed(st_d[c]));
            v = y[DW-1:0];
`else
            v = st_d[c];
`endif
            hist.push_back(v);
            nw++;
            t = c + 1;
            if (nw == FL || (nw > FL && (nw - FL) % HOP == 0)) begin
               if (t > last_s + FL - 2)  s = t + 2;
               else if (t <= last_s - 2) s = -1;
               else                      s = last_s + FL;
               if (s < 0) ex_drop[t] = 1'b1;
               else begin
                  last_s = s;
                  for (int i = 0; i < FL; i++) begin
                     if (s + i <= n) begin
                        ex_en[s+i]    = 1'b1;
                        ex_d[s+i]     = hist[hist.size() - FL + i];
                        ex_first[s+i] = (i == 0);
                        ex_last[s+i]  = (i == FL - 1);
                     end
                  end
               end
            end
         end
      end
      prev = '0; ov = 1'b0;
      for (int k = 1; k <= n; k++) begin
         if (ex_rsted[k]) begin prev = '0; ov = 1'b0; end
         if (ex_drop[k]) ov = 1'b1;
         if (ex_en[k]) prev = ex_d[k];
         ex_d[k]   = prev;
         ex_ovf[k] = ov;
      end
   endtask

   task automatic run_stim(input int n);
      @(negedge clk);
      for (int c = 0; c < n; c++) begin
         rst = st_rst[c]; di_en = st_en[c]; data_i = st_d[c];
         @(posedge clk);
         @(negedge clk);
         ob_en[c+1] = do_en; ob_first[c+1] = do_first; ob_last[c+1] = do_last;
         ob_ovf[c+1] = ovf;  ob_d[c+1] = data_o;
      end
      rst = 1'b0; di_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; di_en = 1'b0; data_i = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if ({do_en, do_first, do_last, ovf, data_o} !== {4'b0000, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL reset cyc %0d: en=%b first=%b last=%b ovf=%b data=%0d, want all 0",
                     c, do_en, do_first, do_last, ovf, data_o);
         end
      end
   endtask

   task automatic test_ramp_slow();
      int n = 40;
      clear_stim();
      for (int i = 0; i < 8; i++) begin st_en[1+i] = 1'b1; st_d[1+i] = DW'(i); end
      for (int i = 0; i < 4; i++) begin st_en[11+3*i] = 1'b1; st_d[11+3*i] = DW'(8+i); end
      run_stim(n);
      build_expected(n);
      for (int k = 1; k <= n; k++) begin
         checks++;
         if ({ob_en[k], ob_first[k], ob_last[k], ob_ovf[k]} !== {ex_en[k], ex_first[k], ex_last[k], ex_ovf[k]}) begin
            errors++;
            $display("FAIL ramp_slow flags @%0d: got en/f/l/ovf=%b%b%b%b want %b%b%b%b", k,
                     ob_en[k], ob_first[k], ob_last[k], ob_ovf[k], ex_en[k], ex_first[k], ex_last[k], ex_ovf[k]);
         end
         checks++;
         if (ob_d[k] !== ex_d[k]) begin
            errors++;
            $display("FAIL ramp_slow data @%0d: got %0d want %0d", k, ob_d[k], ex_d[k]);
         end
      end
      for (int i = 0; i < FL; i++) begin
         checks++;
         if (ob_d[11+i] !== DW'(i)) begin
            errors++;
            $display("FAIL ramp_slow first frame[%0d]: got %0d want %0d", i, ob_d[11+i], i);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n = 45;
      clear_stim();
      for (int i = 0; i < 16; i++) begin st_en[1+i] = 1'b1; st_d[1+i] = DW'(i); end
      run_stim(n);
      build_expected(n);
      for (int k = 1; k <= n; k++) begin
         checks++;
         if ({ob_en[k], ob_first[k], ob_last[k], ob_ovf[k]} !== {ex_en[k], ex_first[k], ex_last[k], ex_ovf[k]}) begin
            errors++;
            $display("FAIL b2b flags @%0d: got en/f/l/ovf=%b%b%b%b want %b%b%b%b", k,
                     ob_en[k], ob_first[k], ob_last[k], ob_ovf[k], ex_en[k], ex_first[k], ex_last[k], ex_ovf[k]);
         end
         checks++;
         if (ob_d[k] !== ex_d[k]) begin
            errors++;
            $display("FAIL b2b data @%0d: got %0d want %0d", k, ob_d[k], ex_d[k]);
         end
      end
      for (int i = 0; i < FL; i++) begin
         checks++;
         if (ob_d[19+i] !== DW'(4+i) || ob_en[19+i] !== 1'b1) begin
            errors++;
            $display("FAIL b2b second frame[%0d]: got en=%b data=%0d want en=1 data=%0d", i, ob_en[19+i], ob_d[19+i], 4+i);
         end
      end
      checks++;
      if (ob_ovf[n] !== 1'b1) begin
         errors++;
         $display("FAIL b2b ovf sticky: got %b want 1", ob_ovf[n]);
      end
   endtask

   task automatic test_reset_mid_frame();
      int n = 50;
      clear_stim();
      for (int i = 0; i < 8; i++) begin st_en[1+i] = 1'b1; st_d[1+i] = DW'(i); end
      st_rst[14] = 1'b1;
      for (int i = 0; i < 8; i++) begin st_en[16+2*i] = 1'b1; st_d[16+2*i] = DW'(100+i); end
      run_stim(n);
      build_expected(n);
      for (int k = 1; k <= n; k++) begin
         checks++;
         if ({ob_en[k], ob_first[k], ob_last[k], ob_ovf[k]} !== {ex_en[k], ex_first[k], ex_last[k], ex_ovf[k]}) begin
            errors++;
            $display("FAIL rst_mid flags @%0d: got en/f/l/ovf=%b%b%b%b want %b%b%b%b", k,
                     ob_en[k], ob_first[k], ob_last[k], ob_ovf[k], ex_en[k], ex_first[k], ex_last[k], ex_ovf[k]);
         end
         checks++;
         if (ob_d[k] !== ex_d[k]) begin
            errors++;
            $display("FAIL rst_mid data @%0d: got %0d want %0d", k, ob_d[k], ex_d[k]);
         end
      end
      checks++;
      if (ob_en[15] !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid do_en after reset edge: got %b want 0", ob_en[15]);
      end
   endtask

   task automatic test_random();
      int n = 200;
      int pct;
      for (int r = 0; r < 4; r++) begin
         clear_stim();
         pct = $urandom_range(20, 95);
         for (int c = 1; c < n; c++) begin
            st_en[c]  = ($urandom_range(0, 99) < pct);
            st_d[c]   = DW'($urandom_range(0, 16383));
            st_rst[c] = ($urandom_range(0, 149) == 0);
         end
         run_stim(n);
         build_expected(n);
         for (int k = 1; k <= n; k++) begin
            checks++;
            if ({ob_en[k], ob_first[k], ob_last[k], ob_ovf[k]} !== {ex_en[k], ex_first[k], ex_last[k], ex_ovf[k]}) begin
               errors++;
               $display("FAIL random run%0d flags @%0d: got en/f/l/ovf=%b%b%b%b want %b%b%b%b", r, k,
                        ob_en[k], ob_first[k], ob_last[k], ob_ovf[k], ex_en[k], ex_first[k], ex_last[k], ex_ovf[k]);
            end
            checks++;
            if (ob_d[k] !== ex_d[k]) begin
               errors++;
               $display("FAIL random run%0d data @%0d: got %0d want %0d", r, k, ob_d[k], ex_d[k]);
            end
         end
      end
   endtask

`ifdef FRAMER_PREEMPH_EN
   task automatic test_preemph();
      int n = 40;
      clear_stim();
      for (int i = 0; i < 8; i++) begin st_en[1+i] = 1'b1; st_d[1+i] = DW'(1024); end
      st_en[9]  = 1'b1; st_d[9]  = 14'h2000;
      st_en[10] = 1'b1; st_d[10] = 14'h1FFF;
      for (int i = 0; i < 6; i++) st_en[11+i] = 1'b1;
      run_stim(n);
      build_expected(n);
      for (int k = 1; k <= n; k++) begin
         checks++;
         if ({ob_en[k], ob_ovf[k], ob_d[k]} !== {ex_en[k], ex_ovf[k], ex_d[k]}) begin
            errors++;
            $display("FAIL preemph @%0d: got en=%b ovf=%b data=%0d want en=%b ovf=%b data=%0d",
                     k, ob_en[k], ob_ovf[k], ob_d[k], ex_en[k], ex_ovf[k], ex_d[k]);
         end
      end
      checks++;
      if (ob_d[11] !== DW'(1024) || ob_d[12] !== DW'(32)) begin
         errors++;
         $display("FAIL preemph const: got %0d,%0d want 1024,32", ob_d[11], ob_d[12]);
      end
      checks++;
      if (ob_d[24] !== 14'h1FFF) begin
         errors++;
         $display("FAIL preemph saturate: got %h want 1fff", ob_d[24]);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; di_en = 1'b0; data_i = '0;
      test_reset();
      test_ramp_slow();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
`ifdef FRAMER_PREEMPH_EN
      test_preemph();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
